// File: rtl/ps2_pkg.sv
// Shared constants, FSM state encodings and the set-2 scan-code to ASCII translation
// used by the PS/2 key decoder.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    localparam logic [7:0] ASCII_UNMAPPED = 8'h2A;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    // Returns {hit, ascii}. Extended codes only translate for arrows and keypad enter.
    function automatic logic [8:0] scan_to_ascii(input logic [7:0] code,
                                                 input logic       ext,
                                                 input logic       shift);
        logic [7:0] a;
        logic       hit;
        logic       letter;
        a      = 8'h00;
        hit    = 1'b1;
        letter = 1'b0;
        case (code)
            8'h45: a = 8'h30;
            8'h16: a = 8'h31;
            8'h1E: a = 8'h32;
            8'h26: a = 8'h33;
            8'h25: a = 8'h34;
            8'h2E: a = 8'h35;
            8'h36: a = 8'h36;
            8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;
            8'h46: a = 8'h39;
            8'h1C: begin a = 8'h41; letter = 1'b1; end
            8'h32: begin a = 8'h42; letter = 1'b1; end
            8'h21: begin a = 8'h43; letter = 1'b1; end
            8'h23: begin a = 8'h44; letter = 1'b1; end
            8'h24: begin a = 8'h45; letter = 1'b1; end
            8'h2B: begin a = 8'h46; letter = 1'b1; end
            8'h34: begin a = 8'h47; letter = 1'b1; end
            8'h33: begin a = 8'h48; letter = 1'b1; end
            8'h43: begin a = 8'h49; letter = 1'b1; end
            8'h3B: begin a = 8'h4A; letter = 1'b1; end
            8'h42: begin a = 8'h4B; letter = 1'b1; end
            8'h4B: begin a = 8'h4C; letter = 1'b1; end
            8'h3A: begin a = 8'h4D; letter = 1'b1; end
            8'h31: begin a = 8'h4E; letter = 1'b1; end
            8'h44: begin a = 8'h4F; letter = 1'b1; end
            8'h4D: begin a = 8'h50; letter = 1'b1; end
            8'h15: begin a = 8'h51; letter = 1'b1; end
            8'h2D: begin a = 8'h52; letter = 1'b1; end
            8'h1B: begin a = 8'h53; letter = 1'b1; end
            8'h2C: begin a = 8'h54; letter = 1'b1; end
            8'h3C: begin a = 8'h55; letter = 1'b1; end
            8'h2A: begin a = 8'h56; letter = 1'b1; end
            8'h1D: begin a = 8'h57; letter = 1'b1; end
            8'h22: begin a = 8'h58; letter = 1'b1; end
            8'h35: begin a = 8'h59; letter = 1'b1; end
            8'h1A: begin a = 8'h5A; letter = 1'b1; end
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            8'h66: a = 8'h08;
            8'h6B: a = 8'h60;
            8'h74: a = 8'h2D;
            8'h75: a = 8'h3D;
            8'h72: a = 8'h5B;
            default: hit = 1'b0;
        endcase
        if (letter && !shift) a = a | 8'h20;
        if (ext && !(code == SC_LEFT || code == SC_RIGHT || code == SC_UP ||
                     code == SC_DOWN || code == SC_ENTER)) hit = 1'b0;
        if (!hit) a = 8'h00;
        return {hit, a};
    endfunction

endpackage

// File: rtl/ps2_out_fifo.sv
// First-word-fall-through output FIFO with registered head, flags and sticky overflow.
module ps2_out_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] head_n;
    logic             do_push, do_pop;

    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    // Next head comes straight from wr_data when the entry is being written this cycle.
    always_comb begin
        wr_ptr_n = do_push ? wr_ptr + AW'(1) : wr_ptr;
        rd_ptr_n = do_pop  ? rd_ptr + AW'(1) : rd_ptr;
        count_n  = count + CW'(do_push) - CW'(do_pop);
        if (count_n == '0)
            head_n = '0;
        else if (do_push && (wr_ptr == rd_ptr_n))
            head_n = wr_data;
        else
            head_n = mem[rd_ptr_n];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            count   <= count_n;
            rd_data <= head_n;
            empty   <= (count_n == '0);
            full    <= (count_n == CW'(DEPTH));
            if (wr_en && full && !do_pop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: prefix FSM, ASCII translation into an output FIFO and
// arrow-key held state. Define PS2_DEC_SHIFT_EN for shift-aware letter case.
module ps2_key_decoder #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned EMIT_UNMAPPED = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       rd_en,
    input  logic       ovf_clr,
    output logic [7:0] ascii_code,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic [3:0] arrow_held
);
    import ps2_pkg::*;

    logic [1:0] state, state_n;
    logic       is_make, is_break, ext;
    logic       is_ctrl, is_shift_code, upper_case;
    logic       hit;
    logic [7:0] ascii;
    logic       push;
    logic [7:0] push_data;

    assign is_ctrl = (scan_code == SC_BAT_OK) || (scan_code == SC_ACK) ||
                     (scan_code == SC_ECHO)   || (scan_code == SC_RESEND) ||
                     (scan_code == SC_PAUSE);

`ifdef PS2_DEC_SHIFT_EN
    logic lshift, rshift;

    assign is_shift_code = (scan_code == SC_LSHIFT) || (scan_code == SC_RSHIFT);
    assign upper_case    = lshift || rshift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
        end else if (is_make || is_break) begin
            if (scan_code == SC_LSHIFT) lshift <= is_make;
            if (scan_code == SC_RSHIFT) rshift <= is_make;
        end
    end
`else
    assign is_shift_code = 1'b0;
    assign upper_case    = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Prefix tracking; decides whether this byte is a make or a break.
    always_comb begin
        state_n  = state;
        is_make  = 1'b0;
        is_break = 1'b0;
        ext      = 1'b0;
        if (scan_valid) begin
            if (is_ctrl) begin
                state_n = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (scan_code == SC_EXT)      state_n = ST_EXT;
                        else if (scan_code == SC_BRK) state_n = ST_BRK;
                        else                          is_make = 1'b1;
                    end
                    ST_EXT: begin
                        if (scan_code == SC_BRK)      state_n = ST_EXT_BRK;
                        else if (scan_code == SC_EXT) state_n = ST_EXT;
                        else begin
                            is_make = 1'b1;
                            ext     = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        if (scan_code == SC_BRK) state_n = ST_BRK;
                        else begin
                            is_break = 1'b1;
                            state_n  = ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        if (scan_code == SC_EXT)      state_n = ST_EXT;
                        else if (scan_code == SC_BRK) state_n = ST_EXT_BRK;
                        else begin
                            is_break = 1'b1;
                            ext      = 1'b1;
                            state_n  = ST_IDLE;
                        end
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end
    end

    assign {hit, ascii} = scan_to_ascii(scan_code, ext, upper_case);
    assign push      = is_make && (hit || ((EMIT_UNMAPPED != 0) && !is_shift_code));
    assign push_data = hit ? ascii : ASCII_UNMAPPED;

    // arrow_held = {down, up, right, left}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arrow_held <= 4'b0000;
        end else if (is_make || is_break) begin
            case (scan_code)
                SC_LEFT:  arrow_held[0] <= is_make;
                SC_RIGHT: arrow_held[1] <= is_make;
                SC_UP:    arrow_held[2] <= is_make;
                SC_DOWN:  arrow_held[3] <= is_make;
                default:  ;
            endcase
        end
    end

    ps2_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (push),
        .wr_data  (push_data),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .rd_data  (ascii_code),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: expected ASCII bytes are queued as scan codes
// are driven and compared as the FIFO is drained.
module tb_ps2_key_decoder;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic [7:0] scan_code  = 8'h00;
    logic       scan_valid = 1'b0;
    logic       rd_en      = 1'b0;
    logic       ovf_clr    = 1'b0;
    logic [7:0] ascii_code;
    logic       empty;
    logic       full;
    logic       overflow;
    logic [3:0] arrow_held;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  sb [$];
    logic [7:0]  digits [10];

`ifdef PS2_DEC_SHIFT_EN
    localparam logic [7:0] EXP_A = 8'h61;
`else
    localparam logic [7:0] EXP_A = 8'h41;
`endif

    ps2_key_decoder #(
        .DEPTH         (8),
        .EMIT_UNMAPPED (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .rd_en      (rd_en),
        .ovf_clr    (ovf_clr),
        .ascii_code (ascii_code),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .arrow_held (arrow_held)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; consecutive calls produce back-to-back strobes.
    task automatic send(input logic [7:0] b);
        scan_code  = b;
        scan_valid = 1'b1;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (sb.size() != 0) begin
            check_eq({tag, "_not_empty"}, 8'(empty), 8'h00);
            if (empty) begin
                sb.delete();
                break;
            end
            check_eq({tag, "_data"}, ascii_code, sb.pop_front());
            rd_en = 1'b1;
            @(posedge clk);
            #1;
            rd_en = 1'b0;
        end
        check_eq({tag, "_end_empty"}, 8'(empty), 8'h01);
        check_eq({tag, "_end_ascii"}, ascii_code, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        digits = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_ascii", ascii_code, 8'h00);
        check_eq("rst_empty", 8'(empty), 8'h01);
        check_eq("rst_full", 8'(full), 8'h00);
        check_eq("rst_ovf", 8'(overflow), 8'h00);
        check_eq("rst_arrow", 8'(arrow_held), 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Make/break of A: one entry, visible the cycle after the strobe
        send(8'h1C);
        sb.push_back(EXP_A);
        check_eq("t1_empty_n1", 8'(empty), 8'h00);
        check_eq("t1_head_n1", ascii_code, EXP_A);
        send(8'hF0);
        send(8'h1C);
        drain("t1");

        // Extended up arrow, typematic repeat, extended break
        send(8'hE0);
        send(8'h75);
        sb.push_back(8'h3D);
        check_eq("t2_arrow_make", 8'(arrow_held), 8'h04);
        send(8'hE0);
        send(8'h75);
        sb.push_back(8'h3D);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check_eq("t2_arrow_break", 8'(arrow_held), 8'h00);
        drain("t2");

        // Shift handling around letter A
        send(8'h12);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        send(8'h1C);
`ifdef PS2_DEC_SHIFT_EN
        sb.push_back(8'h41);
        sb.push_back(8'h61);
`else
        sb.push_back(8'h41);
        sb.push_back(8'h41);
`endif
        drain("t3");

        // Fill past DEPTH: ninth make dropped, overflow sticky
        for (int i = 1; i <= 9; i++) begin
            send(digits[i]);
            if (i <= 8) sb.push_back(8'(8'h30 + i));
        end
        check_eq("t4_full", 8'(full), 8'h01);
        check_eq("t4_ovf_set", 8'(overflow), 8'h01);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check_eq("t4_ovf_clr", 8'(overflow), 8'h00);
        ovf_clr = 1'b1;
        send(digits[0]);
        ovf_clr = 1'b0;
        check_eq("t4_ovf_set_wins", 8'(overflow), 8'h01);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        check_eq("t4_ovf_clr2", 8'(overflow), 8'h00);
        check_eq("t4_head_before", ascii_code, sb.pop_front());
        rd_en = 1'b1;
        send(digits[0]);
        rd_en = 1'b0;
        sb.push_back(8'h30);
        check_eq("t4_full_pushpop", 8'(full), 8'h01);
        check_eq("t4_ovf_pushpop", 8'(overflow), 8'h00);
        check_eq("t4_head_after", ascii_code, sb[0]);
        drain("t4");

        // Reset mid-prefix, then non-extended decode and discarded control bytes
        send(8'hE0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("t5_rst_empty", 8'(empty), 8'h01);
        @(posedge clk);
        #1;
        send(8'h74);
        sb.push_back(8'h2D);
        check_eq("t5_arrow_right", 8'(arrow_held), 8'h02);
        send(8'hAA);
        send(8'hFA);
        send(8'h05);
        send(8'hE0);
        send(8'hAA);
        send(8'h1C);
        sb.push_back(EXP_A);
        send(8'hF0);
        send(8'h74);
        check_eq("t5_arrow_clear", 8'(arrow_held), 8'h00);
        drain("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Sequential PS/2 set-2 scan-code decoder between the PS/2 byte receiver and the game/text logic. It consumes one received byte per strobe and tracks E0 (extended) and F0 (break) prefixes and shift state. Make codes are translated to ASCII and buffered in a first-word-fall-through FIFO. It also exports live held-state of the four arrow keys for player control.

## Interface
- `DEPTH`, default 8: output FIFO entries; power of two, 2..64.
- `EMIT_UNMAPPED`, default 0: 1 = unmapped make codes push 8'h2a ('*'); 0 = dropped.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `scan_code` in 8: byte from PS/2 receiver.
- `scan_valid` in 1: one-cycle strobe, `scan_code` valid.
- `rd_en` in 1: pop FIFO head; ignored when `empty`.
- `ovf_clr` in 1: clears `overflow`.
- `ascii_code` out 8: FIFO head (FWFT); 8'h00 when empty.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `overflow` out 1: sticky, set when a push is dropped.
- `arrow_held` out 4: {down, up, right, left} currently pressed.

## Operation
- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
- IDLE: E0→EXT, F0→BRK, other→make(code, ext=0), stay IDLE.
- EXT: F0→EXT_BRK, E0→EXT, other→make(code, ext=1)→IDLE.
- BRK: F0→BRK, other→break(code, ext=0)→IDLE.
- EXT_BRK: any non-prefix→break(code, ext=1)→IDLE.
- Bytes AA, FA, EE, FE, E1 are discarded in any state and force IDLE with no push.
- make: push the mapped ASCII.
  - Digits 0x45,16,1E,26,25,2E,36,3D,3E,46 → '0'..'9'.
  - Letters A–Z → 0x41–0x5A.
  - 29→20, 5A→0D, 66→08.
  - Arrows left 6B→60, right 74→2D, up 75→3D, down 72→5B, with or without E0.
  - Any other code: 2A if `EMIT_UNMAPPED`, else no push.
- Typematic repeat make codes push again.
- Break codes never push.
- Make/break of 6B/74/75/72 (either ext) sets/clears the matching `arrow_held` bit.
- FIFO: push when not full. Push when full without same-cycle pop → dropped, `overflow`←1.
- Push and pop in the same cycle:
  - Full: both occur, count unchanged, no overflow.
  - Empty: push only.
- `ovf_clr` concurrent with a new overflow: set wins.

## Timing
- Every output resets to: `ascii_code` 0, `empty` 1, `full` 0, `overflow` 0, `arrow_held` 0. FSM resets to IDLE and shift state to 0.
- Translation is combinational on `scan_code`. Push and FSM update happen at the `scan_valid` edge.
- A byte at cycle N is visible at `ascii_code` with `empty`=0 in cycle N+1.
- `rd_en` at cycle N: next entry, or empty, appears at N+1.
- `arrow_held` updates at N+1.
- Back-to-back `scan_valid` on every cycle is supported.
- Reset mid-prefix abandons the sequence; the following byte is decoded from IDLE.

## Configuration
- `PS2_DEC_SHIFT_EN` defined:
  - Shift state = L-shift (12) held OR R-shift (59) held, updated on make/break.
  - Letters push lowercase (0x61–0x7A) when shift is not held, uppercase when held.
  - Shift codes themselves never push.
- Undefined:
  - Letters are always uppercase.
  - 12 and 59 are treated as ordinary unmapped codes.

## Structure
- Package `ps2_pkg`:
  - Prefix/control byte constants (E0, F0, E1, AA, FA, EE, FE, 12, 59).
  - Arrow codes and FSM state enum.
  - Pure function `scan_to_ascii(code, ext, shift) → {hit, ascii}`.
- Sub-module `ps2_out_fifo` (DEPTH, width 8, FWFT, full/empty/overflow) instantiated once.

## Test plan
- Bytes 1C, F0, 1C → one entry 0x41 (macro off) or 0x61 (macro on); `empty`=0 one cycle after the strobe.
- E0 75, then E0 F0 75 → push 0x3D; `arrow_held`=4'b0100 after the make, 0 after the break.
- Macro on: 12, 1C, F0 1C, F0 12, 1C → entries 0x41 then 0x61 only.
- DEPTH=8: push 9 makes with no reads → `full`=1, `overflow`=1, 8 entries preserved in order. `ovf_clr` → 0.
- When full, push and `rd_en` in the same cycle → count stays 8, `overflow` stays 0, head advances.
- E0 then `rst_n` pulse, then 74 → decoded non-extended, push 0x2D. AA and FA → no push.
